// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Round-robin tie-break is enabled by defining RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam bit PORT_A = 1'b0;
  localparam bit PORT_B = 1'b1;

  function automatic int burst_cnt_width(input int mb);
    return $clog2(mb + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request grant logic; round-robin with a last-served pointer when
// RAM_ARB_ROUND_ROBIN_EN is defined, fixed priority (A first) otherwise.
module rr_arb2
  import ram_arb_pkg::*;
(
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_update,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_last_b;

  // Pointer starts at B so that A wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_b <= 1'b1;
    else if (i_update) r_last_b <= o_gnt[PORT_B];
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT_A] && i_req[PORT_B]) o_gnt = r_last_b ? 2'b01 : 2'b10;
    else if (i_req[PORT_A])             o_gnt = 2'b01;
    else if (i_req[PORT_B])             o_gnt = 2'b10;
  end
`else
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT_A])      o_gnt = 2'b01;
    else if (i_req[PORT_B]) o_gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between ports A and B with lock/burst ownership.
// Tie-break mode selected by RAM_ARB_ROUND_ROBIN_EN (default: fixed priority).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int addr_width = 7,
  parameter int data_width = 10,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [data_width-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [data_width-1:0] b_rdata,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  localparam int CNT_W = burst_cnt_width(max_burst);

  owner_t                r_owner, w_owner_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt, w_cur_cnt;
  logic [1:0]            w_req, w_gnt;
  logic                  w_own_a, w_own_b, w_any, w_lock, w_continue;
  logic [addr_width-1:0] r_last_addr;
  logic [data_width-1:0] r_last_din;

  assign w_own_a    = (r_owner == OWN_A) && a_valid;
  assign w_own_b    = (r_owner == OWN_B) && b_valid;
  assign w_any      = |w_gnt;
  assign w_lock     = w_gnt[PORT_A] ? a_lock : b_lock;
  // A burst count only carries over while the owner keeps its request up.
  assign w_cur_cnt  = (w_own_a || w_own_b) ? r_count : '0;
  assign w_continue = (int'(w_cur_cnt) + 1) < max_burst;

  always_comb begin
    w_req = {b_valid, a_valid};
    if (!rst_n)       w_req = 2'b00;
    else if (w_own_a) w_req = 2'b01;
    else if (w_own_b) w_req = 2'b10;
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic w_rr_update;
  assign w_rr_update = w_any && !(w_lock && w_continue);
`endif

  rr_arb2 u_arb (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .i_update (w_rr_update),
`endif
    .i_req    (w_req),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_count <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_count_nxt = '0;
    if (w_any && w_lock && w_continue) begin
      w_owner_nxt = w_gnt[PORT_A] ? OWN_A : OWN_B;
      w_count_nxt = w_cur_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    a_ready  = w_gnt[PORT_A];
    b_ready  = w_gnt[PORT_B];
    ram_we   = 1'b0;
    ram_addr = r_last_addr;
    ram_din  = r_last_din;
    if (w_gnt[PORT_A]) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (w_gnt[PORT_B]) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  // Idle cycles replay the last granted address/data to avoid bus toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
      r_last_din  <= '0;
    end else if (w_any) begin
      r_last_addr <= ram_addr;
      r_last_din  <= ram_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= w_gnt[PORT_A] && !a_we;
      b_rvalid <= w_gnt[PORT_B] && !b_we;
      if (w_gnt[PORT_A] && !a_we) a_rdata <= ram_dout;
      if (w_gnt[PORT_B] && !b_we) b_rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scenario bench for ram_port_arbiter with a behavioural RAM and a read scoreboard.
// Expected grant order follows RAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 10;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          aValid, aReady, aWe, aLock, aRvalid;
  logic          bValid, bReady, bWe, bLock, bRvalid;
  logic [AW-1:0] aAddr, bAddr, ramAddr;
  logic [DW-1:0] aWdata, bWdata, aRdata, bRdata, ramDin, ramDout;
  logic          ramWe;

  int nChecks = 0;
  int nFails  = 0;

  logic [DW-1:0] qA[$];
  logic [DW-1:0] qB[$];
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] expData;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rstN),
    .a_valid  (aValid),
    .a_ready  (aReady),
    .a_we     (aWe),
    .a_lock   (aLock),
    .a_addr   (aAddr),
    .a_wdata  (aWdata),
    .a_rvalid (aRvalid),
    .a_rdata  (aRdata),
    .b_valid  (bValid),
    .b_ready  (bReady),
    .b_we     (bWe),
    .b_lock   (bLock),
    .b_addr   (bAddr),
    .b_wdata  (bWdata),
    .b_rvalid (bRvalid),
    .b_rdata  (bRdata),
    .ram_we   (ramWe),
    .ram_addr (ramAddr),
    .ram_din  (ramDin),
    .ram_dout (ramDout)
  );

  // Behavioural single-port RAM: synchronous write, combinational read.
  assign ramDout = mem[ramAddr];
  always @(posedge clk) if (ramWe) mem[ramAddr] <= ramDin;

  // Scoreboard: every expected read must return exactly one cycle after grant.
  always begin
    @(posedge clk);
    #1;
    nChecks++;
    if (qA.size() > 0) begin
      expData = qA.pop_front();
      if (aRvalid !== 1'b1 || aRdata !== expData) begin
        nFails++;
        $display("[TB] FAIL a_read_return: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h", aRvalid, aRdata, expData);
      end
    end else if (aRvalid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL a_spurious_rvalid: rvalid=%b, expected 0", aRvalid);
    end
    nChecks++;
    if (qB.size() > 0) begin
      expData = qB.pop_front();
      if (bRvalid !== 1'b1 || bRdata !== expData) begin
        nFails++;
        $display("[TB] FAIL b_read_return: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h", bRvalid, bRdata, expData);
      end
    end else if (bRvalid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL b_spurious_rvalid: rvalid=%b, expected 0", bRvalid);
    end
  end

  task automatic applyStimulus(input logic av, input logic aw, input logic al,
                               input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic bv, input logic bw, input logic bl,
                               input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    aValid = av; aWe = aw; aLock = al; aAddr = aa; aWdata = ad;
    bValid = bv; bWe = bw; bLock = bl; bAddr = ba; bWdata = bd;
  endtask

  task automatic recordAccess(input bit port, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (we) model[addr] = data;
    else if (port == 1'b0) qA.push_back(model[addr]);
    else qB.push_back(model[addr]);
  endtask

  task automatic applyIdle;
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 10'd0, 1'b0, 1'b0, 1'b0, 7'd0, 10'd0);
  endtask

  task automatic test_reset_initial;
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd9, 10'h05, 1'b1, 1'b0, 1'b0, 7'd2, 10'd0);
    #3;
    nChecks++;
    if ({aRvalid, bRvalid, ramWe, aReady, bReady} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: rv_a/rv_b/we/rdy_a/rdy_b=%b, expected 00000", {aRvalid, bRvalid, ramWe, aReady, bReady});
    end
    nChecks++;
    if ({aRdata, bRdata, ramAddr, ramDin} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_data: a_rdata=%h b_rdata=%h ram_addr=%h ram_din=%h, expected all 0", aRdata, bRdata, ramAddr, ramDin);
    end
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 10'd0, 1'b1, 1'b0, 1'b1, 7'd3, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL rst_pre_grant0: ready a/b=%b%b, expected 01", aReady, bReady);
    end
    recordAccess(1'b1, 1'b0, 7'd3, 10'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd40, 10'h3C3, 1'b1, 1'b0, 1'b1, 7'd4, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL rst_owner_b: ready a/b=%b%b, expected 01", aReady, bReady);
    end
    recordAccess(1'b1, 1'b0, 7'd4, 10'd0);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    qA.delete();
    qB.delete();
    #1;
    nChecks++;
    if ({aRvalid, bRvalid, ramWe, aReady, bReady} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL rst_async_ctrl: rv_a/rv_b/we/rdy_a/rdy_b=%b, expected 00000", {aRvalid, bRvalid, ramWe, aReady, bReady});
    end
    nChecks++;
    if ({aRdata, bRdata, ramAddr, ramDin} !== '0) begin
      nFails++;
      $display("[TB] FAIL rst_async_data: a_rdata=%h b_rdata=%h ram_addr=%h ram_din=%h, expected all 0", aRdata, bRdata, ramAddr, ramDin);
    end
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd6, 10'd0, 1'b1, 1'b0, 1'b0, 7'd7, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL rst_first_tie: ready a/b=%b%b, expected 10", aReady, bReady);
    end
    recordAccess(1'b0, 1'b0, 7'd6, 10'd0);
  endtask

  task automatic test_write_read;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd5, 10'h155, 1'b0, 1'b0, 1'b0, 7'd0, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady, ramWe} !== 3'b101 || ramAddr !== 7'd5 || ramDin !== 10'h155) begin
      nFails++;
      $display("[TB] FAIL wr_bus: rdy_a/rdy_b/we=%b addr=%h din=%h, expected 101 addr=05 din=155", {aReady, bReady, ramWe}, ramAddr, ramDin);
    end
    recordAccess(1'b0, 1'b1, 7'd5, 10'h155);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 10'd0, 1'b1, 1'b0, 1'b0, 7'd5, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady, ramWe} !== 3'b010 || ramAddr !== 7'd5) begin
      nFails++;
      $display("[TB] FAIL rd_bus: rdy_a/rdy_b/we=%b addr=%h, expected 010 addr=05", {aReady, bReady, ramWe}, ramAddr);
    end
    recordAccess(1'b1, 1'b0, 7'd5, 10'd0);
  endtask

  task automatic test_alternate;
    logic expA;
    for (int i = 0; i < 6; i++) begin
      expA = RR_ON ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'(10 + i), 10'd0, 1'b1, 1'b0, 1'b0, 7'(50 + i), 10'd0);
      #1;
      nChecks++;
      if ({aReady, bReady} !== {expA, ~expA}) begin
        nFails++;
        $display("[TB] FAIL alternate[%0d]: ready a/b=%b%b, expected %b%b", i, aReady, bReady, expA, ~expA);
      end
      if (expA) recordAccess(1'b0, 1'b0, 7'(10 + i), 10'd0);
      else recordAccess(1'b1, 1'b0, 7'(50 + i), 10'd0);
    end
  endtask

  task automatic test_burst;
    logic expA;
    for (int i = 0; i < 6; i++) begin
      expA = RR_ON ? (i != 4) : 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b1, 7'(20 + i), 10'(10'h200 + i), 1'b1, 1'b0, 1'b0, 7'd5, 10'd0);
      #1;
      nChecks++;
      if ({aReady, bReady} !== {expA, ~expA}) begin
        nFails++;
        $display("[TB] FAIL burst[%0d]: ready a/b=%b%b, expected %b%b", i, aReady, bReady, expA, ~expA);
      end
      if (expA) recordAccess(1'b0, 1'b1, 7'(20 + i), 10'(10'h200 + i));
      else recordAccess(1'b1, 1'b0, 7'd5, 10'd0);
    end
  endtask

  task automatic test_lock_drop;
    logic expA;
    @(negedge clk);
    applyIdle();
    #1;
    nChecks++;
    if ({aReady, bReady, ramWe} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL drop_idle: rdy_a/rdy_b/we=%b, expected 000", {aReady, bReady, ramWe});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'(20 + i), 10'd0, 1'b1, 1'b0, 1'b0, 7'd60, 10'd0);
      #1;
      nChecks++;
      if ({aReady, bReady} !== 2'b10) begin
        nFails++;
        $display("[TB] FAIL drop_lock[%0d]: ready a/b=%b%b, expected 10", i, aReady, bReady);
      end
      recordAccess(1'b0, 1'b0, 7'(20 + i), 10'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd0, 10'd0, 1'b1, 1'b0, 1'b0, 7'd60, 10'd0);
    #1;
    nChecks++;
    if ({aReady, bReady} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL drop_b_next: ready a/b=%b%b, expected 01", aReady, bReady);
    end
    recordAccess(1'b1, 1'b0, 7'd60, 10'd0);
    for (int i = 0; i < 5; i++) begin
      expA = RR_ON ? (i < 4) : 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'd21, 10'd0, 1'b1, 1'b0, 1'b0, 7'd61, 10'd0);
      #1;
      nChecks++;
      if ({aReady, bReady} !== {expA, ~expA}) begin
        nFails++;
        $display("[TB] FAIL drop_reburst[%0d]: ready a/b=%b%b, expected %b%b", i, aReady, bReady, expA, ~expA);
      end
      if (expA) recordAccess(1'b0, 1'b0, 7'd21, 10'd0);
      else recordAccess(1'b1, 1'b0, 7'd61, 10'd0);
    end
  endtask

  task automatic test_idle;
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'd33, 10'h0AB, 1'b0, 1'b0, 1'b0, 7'd0, 10'd0);
    #1;
    nChecks++;
    if ({aReady, ramWe} !== 2'b11) begin
      nFails++;
      $display("[TB] FAIL idle_write: rdy_a/we=%b, expected 11", {aReady, ramWe});
    end
    recordAccess(1'b0, 1'b1, 7'd33, 10'h0AB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyIdle();
      #1;
      nChecks++;
      if ({aReady, bReady, ramWe} !== 3'b000 || ramAddr !== 7'd33 || ramDin !== 10'h0AB) begin
        nFails++;
        $display("[TB] FAIL idle_hold[%0d]: rdy_a/rdy_b/we=%b addr=%h din=%h, expected 000 addr=21 din=0ab", i, {aReady, bReady, ramWe}, ramAddr, ramDin);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 10'd0, 1'b1, 1'b0, 1'b0, 7'd33, 10'd0);
    #1;
    nChecks++;
    if (bReady !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL idle_readback: b_ready=%b, expected 1", bReady);
    end
    recordAccess(1'b1, 1'b0, 7'd33, 10'd0);
    @(negedge clk);
    applyIdle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]   = 10'((i * 37 + 11) % 1024);
      model[i] = 10'((i * 37 + 11) % 1024);
    end
    test_reset_initial();
    test_reset();
    test_write_read();
    test_alternate();
    test_burst();
    test_lock_drop();
    test_idle();
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
